// File: rtl/cache_slot_allocator.sv
// Slot allocator for the 32-word shared PE cache: free-bitmask pool, round-robin grants, releases, drain/flush.
// Optional ALLOC_STATS_EN adds peak_used and stall_cnt statistics outputs.
module cache_slot_allocator #(
  parameter int Num_Req       = 4,
  parameter int Slots         = 32,
  parameter int Address_Width = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [Num_Req-1:0]               req,
  output logic [Num_Req-1:0]               gnt,
  output logic [Address_Width-1:0]         gnt_addr,
  input  logic [Num_Req-1:0]               free_vld,
  input  logic [Num_Req*Address_Width-1:0] free_addr,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic [Address_Width:0]           free_count,
  output logic                             full,
  output logic                             err
`ifdef ALLOC_STATS_EN
  ,
  output logic [Address_Width:0]           peak_used,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int RrW = (Num_Req > 1) ? $clog2(Num_Req) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [Slots-1:0]         free_mask, mask_nxt, rel_seen;
  logic [RrW-1:0]           rr_ptr, win_idx;
  logic                     win_vld, do_grant, dbl_free, found;
  logic [Num_Req-1:0]       eligible, gnt_nxt;
  logic [Address_Width-1:0] low_addr, rel_a;
  logic [Address_Width:0]   cnt_nxt;

  assign full       = (free_count == '0);
  assign flush_done = (state == DONE);

  always_comb begin
    eligible = req & ~gnt;
    win_vld  = 1'b0;
    win_idx  = '0;
    for (int unsigned k = 0; k < int'(Num_Req); k++) begin
      int unsigned j;
      j = (32'(rr_ptr) + k) % Num_Req;
      if (!win_vld && eligible[j]) begin
        win_vld = 1'b1;
        win_idx = RrW'(j);
      end
    end

    found    = 1'b0;
    low_addr = '0;
    for (int unsigned s = 0; s < int'(Slots); s++) begin
      if (!found && free_mask[s]) begin
        found    = 1'b1;
        low_addr = Address_Width'(s);
      end
    end

    do_grant = (state == RUN) && !full && win_vld && found;
    gnt_nxt  = '0;
    if (do_grant) gnt_nxt[win_idx] = 1'b1;

    mask_nxt = free_mask;
    if (do_grant) mask_nxt[low_addr] = 1'b0;

    // A release hitting a slot free before this edge (including the one being granted) or already
    // released by a lower-numbered PE this cycle is a double free; the slot ends up free either way.
    rel_seen = '0;
    dbl_free = 1'b0;
    for (int unsigned i = 0; i < int'(Num_Req); i++) begin
      rel_a = free_addr[i*Address_Width +: Address_Width];
      if (free_vld[i]) begin
        if (free_mask[rel_a] || rel_seen[rel_a]) dbl_free = 1'b1;
        rel_seen[rel_a] = 1'b1;
      end
    end
    mask_nxt = mask_nxt | rel_seen;

    cnt_nxt = '0;
    for (int unsigned s = 0; s < int'(Slots); s++) begin
      cnt_nxt = cnt_nxt + (Address_Width+1)'(mask_nxt[s]);
    end

    state_nxt = state;
    case (state)
      RUN:     if (flush_req) state_nxt = DRAIN;
      DRAIN:   if (free_count == (Address_Width+1)'(Slots)) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      free_mask  <= '1;
      free_count <= (Address_Width+1)'(Slots);
      gnt        <= '0;
      gnt_addr   <= '0;
      rr_ptr     <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      free_mask  <= mask_nxt;
      free_count <= cnt_nxt;
      gnt        <= gnt_nxt;
      if (dbl_free) err <= 1'b1;
      if (do_grant) begin
        gnt_addr <= low_addr;
        rr_ptr   <= (32'(win_idx) == Num_Req - 1) ? '0 : win_idx + 1'b1;
      end
      if (state == DONE) rr_ptr <= '0;
    end
  end

`ifdef ALLOC_STATS_EN
  logic [Address_Width:0] used_nxt;
  assign used_nxt = (Address_Width+1)'(Slots) - cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_used <= '0;
      stall_cnt <= '0;
    end else if (state == DONE) begin
      peak_used <= '0;
      stall_cnt <= '0;
    end else begin
      if (used_nxt > peak_used) peak_used <= used_nxt;
      if ((state == RUN) && full && (|req) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_slot_allocator.sv
// Directed self-checking bench for cache_slot_allocator (statistics checks included when ALLOC_STATS_EN is defined).
module tb_cache_slot_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [4:0]  gnt_addr;
  logic [3:0]  free_vld;
  logic [19:0] free_addr;
  logic        flush_req;
  logic        flush_done;
  logic [5:0]  free_count;
  logic        full;
  logic        err;
`ifdef ALLOC_STATS_EN
  logic [5:0]  peak_used;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  cache_slot_allocator #(.Num_Req(4), .Slots(32), .Address_Width(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_addr(gnt_addr),
    .free_vld(free_vld), .free_addr(free_addr), .flush_req(flush_req),
    .flush_done(flush_done), .free_count(free_count), .full(full), .err(err)
`ifdef ALLOC_STATS_EN
    , .peak_used(peak_used), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rel(input int pe, input int addr);
    free_vld[pe] = 1'b1;
    free_addr[pe*5 +: 5] = 5'(addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; free_vld = '0; free_addr = '0; flush_req = 1'b0;
    #7;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_free_count", 32'(free_count), 32);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // single request
    do_reset();
    check("rst_addr", 32'(gnt_addr), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    req = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_addr", 32'(gnt_addr), 0);
    check("t1_count", 32'(free_count), 31);
    req = '0;
    tick();
    check("t1_gnt_drop", 32'(gnt), 0);

    // round robin over all four
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      check("rr_addr", 32'(gnt_addr), 32'(k));
    end
    check("rr_count", 32'(free_count), 24);
    req = '0;

    // exhaust pool, then a release unblocks a pending request
    do_reset();
    req = 4'b1111;
    repeat (32) tick();
    check("full_last_gnt", 32'(gnt), 32'h8);
    check("full_last_addr", 32'(gnt_addr), 31);
    check("full_count", 32'(free_count), 0);
    check("full_flag", 32'(full), 1);
    req = 4'b0010;
    tick();
    check("full_nogrant_a", 32'(gnt), 0);
    tick();
    check("full_nogrant_b", 32'(gnt), 0);
    rel(3, 17);
    tick();
    check("rel_same_edge_nogrant", 32'(gnt), 0);
    check("rel_count", 32'(free_count), 1);
    check("rel_not_full", 32'(full), 0);
    free_vld = '0;
    tick();
    check("rel_gnt", 32'(gnt), 32'h2);
    check("rel_addr", 32'(gnt_addr), 17);
    check("rel_full_again", 32'(full), 1);
`ifdef ALLOC_STATS_EN
    check("peak_used_full", 32'(peak_used), 32);
    check("stall_cnt", 32'(stall_cnt), 3);
`endif
    req = '0;

    // duplicate release across PEs in one cycle
    do_reset();
    req = 4'b1111;
    repeat (4) tick();
    req = '0;
    rel(0, 2);
    rel(1, 2);
    tick();
    free_vld = '0;
    check("dup_count", 32'(free_count), 29);
    check("dup_err", 32'(err), 1);
    tick();
    tick();
    check("dup_err_sticky", 32'(err), 1);

    // flush with five slots held
    do_reset();
    req = 4'b1111;
    repeat (5) tick();
    req = '0;
    flush_req = 1'b1;
    tick();
    check("fl_enter_gnt", 32'(gnt), 0);
    check("fl_enter_count", 32'(free_count), 27);
    flush_req = 1'b0;
    req = 4'b1111;
    tick();
    check("fl_drain_gnt", 32'(gnt), 0);
    rel(0, 0); rel(1, 1);
    tick();
    check("fl_rel1_count", 32'(free_count), 29);
    check("fl_rel1_gnt", 32'(gnt), 0);
    free_vld = '0;
    rel(0, 2); rel(1, 3);
    tick();
    check("fl_rel2_count", 32'(free_count), 31);
    free_vld = '0;
    rel(2, 4);
    tick();
    free_vld = '0;
    check("fl_rel3_count", 32'(free_count), 32);
    check("fl_done_early", 32'(flush_done), 0);
    check("fl_err_clean", 32'(err), 0);
    tick();
    check("fl_done_pulse", 32'(flush_done), 1);
    check("fl_done_gnt", 32'(gnt), 0);
    tick();
    check("fl_done_end", 32'(flush_done), 0);
    check("fl_post_gnt0", 32'(gnt), 0);
    tick();
    check("fl_resume_gnt", 32'(gnt), 32'h1);
    check("fl_resume_addr", 32'(gnt_addr), 0);
    req = '0;

    // asynchronous reset mid-grant
    do_reset();
    req = 4'b1111;
    repeat (10) tick();
    check("ar_pre_gnt", 32'(gnt), 32'h2);
    check("ar_pre_count", 32'(free_count), 22);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_count", 32'(free_count), 32);
    check("ar_err", 32'(err), 0);
`ifdef ALLOC_STATS_EN
    check("ar_peak", 32'(peak_used), 0);
    check("ar_stall", 32'(stall_cnt), 0);
`endif
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
